// File: rtl/game_ctrl_fsm.sv
// Game-control sequencer for a falling-block puzzle game.
// Steps IDLE -> SPAWN -> FALL -> LOCK -> CLEAR, with pause, a lock delay,
// line/level bookkeeping and a level-scaled gravity timer that emits drop ticks.
module game_ctrl_fsm #(
    parameter int unsigned GRAV_W          = 16,
    parameter int unsigned GRAV_BASE       = 50000,
    parameter int unsigned GRAV_STEP       = 4000,
    parameter int unsigned GRAV_MIN        = 2000,
    parameter int unsigned LOCK_TICKS      = 30,
    parameter int unsigned LEVEL_W         = 4,
    parameter int unsigned LINES_W         = 12,
    parameter int unsigned LINES_PER_LEVEL = 10
) (
    input  logic               in_clk,
    input  logic               in_rst_n,
    input  logic               restart,
    input  logic               start,
    input  logic               pause,
    input  logic               placed,
    input  logic               game_over,
    input  logic               spawn_done,
    input  logic               clear_done,
    input  logic [2:0]         lines_cleared,
    output logic [2:0]         state,
    output logic               spawn_req,
    output logic               clear_req,
    output logic               drop_tick,
    output logic [LEVEL_W-1:0] level,
    output logic [LINES_W-1:0] lines_total
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSpawn  = 3'd1,
        StFall   = 3'd2,
        StLock   = 3'd3,
        StClear  = 3'd4,
        StPaused = 3'd5,
        StOver   = 3'd6
    } state_e;

    // Period arithmetic is done wide enough that level*step cannot wrap.
    localparam int unsigned PW     = GRAV_W + LEVEL_W;
    localparam int unsigned LOCK_W = (LOCK_TICKS > 1) ? $clog2(LOCK_TICKS) : 1;
    // Progress may carry a remainder above one level's worth after a big clear.
    localparam int unsigned PROG_W = $clog2(LINES_PER_LEVEL + 8) + 1;

    localparam logic [PW-1:0]     BASE_V    = PW'(GRAV_BASE);
    localparam logic [PW-1:0]     STEP_V    = PW'(GRAV_STEP);
    localparam logic [PW-1:0]     MIN_V     = PW'(GRAV_MIN);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TICKS - 1);
    localparam logic [PROG_W-1:0] LPL_V     = PROG_W'(LINES_PER_LEVEL);

    state_e              r_state;
    state_e              r_saved;
    logic [GRAV_W-1:0]   r_grav_cnt;
    logic [LOCK_W-1:0]   r_lock_cnt;
    logic [LEVEL_W-1:0]  r_level;
    logic [LINES_W-1:0]  r_lines;
    logic [PROG_W-1:0]   r_progress;
    logic                r_spawn_req;
    logic                r_clear_req;
    logic                r_drop_tick;

    logic [PW-1:0]       w_dec;
    logic [PW-1:0]       w_period;
    logic [PW-1:0]       w_grav_ext;
    logic                w_grav_last;
    logic [LINES_W:0]    w_lines_sum;
    logic [LINES_W-1:0]  w_lines_next;
    logic [PROG_W:0]     w_prog_sum;
    logic [PROG_W-1:0]   w_prog_sat;
    logic                w_level_up;
    logic [PROG_W-1:0]   w_prog_next;
    logic                w_over;
    logic                w_pause_hit;

    // Drop period: base minus level scaling, floored at the minimum without underflow.
    assign w_dec       = PW'(r_level) * STEP_V;
    assign w_period    = ((BASE_V > w_dec) && ((BASE_V - w_dec) > MIN_V)) ?
                         (BASE_V - w_dec) : MIN_V;
    assign w_grav_ext  = PW'(r_grav_cnt);
    // >= rather than == so a mid-fall level-up that shrinks the period still ticks.
    assign w_grav_last = (w_grav_ext >= (w_period - PW'(1)));

    // Saturating line total.
    assign w_lines_sum  = {1'b0, r_lines} + {{(LINES_W - 2){1'b0}}, lines_cleared};
    assign w_lines_next = w_lines_sum[LINES_W] ? '1 : w_lines_sum[LINES_W-1:0];

    // Level progress: at most one level per clear, remainder carried forward.
    assign w_prog_sum  = {1'b0, r_progress} + {{(PROG_W - 2){1'b0}}, lines_cleared};
    assign w_prog_sat  = w_prog_sum[PROG_W] ? '1 : w_prog_sum[PROG_W-1:0];
    assign w_level_up  = (lines_cleared != 3'd0) && (w_prog_sat >= LPL_V);
    assign w_prog_next = w_level_up ? (w_prog_sat - LPL_V) : w_prog_sat;

    // Top-out is only meaningful while a piece is being spawned or is in play.
    assign w_over      = game_over && (((r_state == StSpawn) && spawn_done) ||
                                       (r_state == StFall) || (r_state == StLock));
    assign w_pause_hit = pause && ((r_state == StFall) || (r_state == StLock) ||
                                   (r_state == StPaused));

    // Sequencer, counters and registered outputs.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state     <= StIdle;
            r_saved     <= StFall;
            r_grav_cnt  <= '0;
            r_lock_cnt  <= '0;
            r_level     <= '0;
            r_lines     <= '0;
            r_progress  <= '0;
            r_spawn_req <= 1'b0;
            r_clear_req <= 1'b0;
            r_drop_tick <= 1'b0;
        end else begin
            r_spawn_req <= (r_state == StSpawn);
            r_clear_req <= (r_state == StClear);
            r_drop_tick <= 1'b0;
            if (restart) begin
                r_state    <= StIdle;
                r_grav_cnt <= '0;
                r_lock_cnt <= '0;
                r_level    <= '0;
                r_lines    <= '0;
                r_progress <= '0;
            end else if (w_over) begin
                r_state <= StOver;
            end else if (w_pause_hit) begin
                if (r_state == StPaused) begin
                    r_state <= r_saved;
                end else begin
                    r_saved <= r_state;
                    r_state <= StPaused;
                end
            end else begin
                case (r_state)
                    StIdle: begin
                        r_grav_cnt <= '0;
                        r_lock_cnt <= '0;
                        if (start) begin
                            r_state <= StSpawn;
                        end
                    end
                    StSpawn: begin
                        if (spawn_done) begin
                            r_state    <= StFall;
                            r_grav_cnt <= '0;
                        end
                    end
                    StFall: begin
                        if (placed) begin
                            r_state    <= StLock;
                            r_lock_cnt <= '0;
                        end else if (w_grav_last) begin
                            r_drop_tick <= 1'b1;
                            r_grav_cnt  <= '0;
                        end else begin
                            r_grav_cnt <= r_grav_cnt + GRAV_W'(1);
                        end
                    end
                    StLock: begin
                        if (!placed) begin
                            r_state    <= StFall;
                            r_lock_cnt <= '0;
                        end else if (r_lock_cnt == LOCK_LAST) begin
                            r_state    <= StClear;
                            r_lock_cnt <= '0;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
                        end
                    end
                    StClear: begin
                        if (clear_done) begin
                            r_state <= StSpawn;
                            r_lines <= w_lines_next;
                            if (lines_cleared != 3'd0) begin
                                r_progress <= w_prog_next;
                                if (w_level_up && (r_level != '1)) begin
                                    r_level <= r_level + LEVEL_W'(1);
                                end
                            end
                        end
                    end
                    StPaused, StOver: begin
                        r_state <= r_state;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign state       = r_state;
    assign spawn_req   = r_spawn_req;
    assign clear_req   = r_clear_req;
    assign drop_tick   = r_drop_tick;
    assign level       = r_level;
    assign lines_total = r_lines;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Bench for game_ctrl_fsm: cycle-by-cycle vectors with expected outputs after each edge.
module tb_game_ctrl_fsm;

    localparam logic [6:0] I_RS = 7'b1000000;
    localparam logic [6:0] I_ST = 7'b0100000;
    localparam logic [6:0] I_PA = 7'b0010000;
    localparam logic [6:0] I_PL = 7'b0001000;
    localparam logic [6:0] I_GO = 7'b0000100;
    localparam logic [6:0] I_SD = 7'b0000010;
    localparam logic [6:0] I_CD = 7'b0000001;

    localparam logic [2:0] O_SR = 3'b100;
    localparam logic [2:0] O_CR = 3'b010;
    localparam logic [2:0] O_TK = 3'b001;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SPAWN = 3'd1;
    localparam logic [2:0] S_FALL  = 3'd2;
    localparam logic [2:0] S_LOCK  = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;
    localparam logic [2:0] S_PAUSE = 3'd5;
    localparam logic [2:0] S_OVER  = 3'd6;

    typedef struct {
        logic [6:0]  in_b;
        logic [2:0]  lc;
        logic [2:0]  es;
        logic [2:0]  eo;
        logic [3:0]  elv;
        logic [11:0] eln;
    } vec_t;

    logic        in_clk;
    logic        in_rst_n;
    logic        restart, start, pause, placed, game_over, spawn_done, clear_done;
    logic [2:0]  lines_cleared;
    logic [2:0]  state;
    logic        spawn_req, clear_req, drop_tick;
    logic [3:0]  level;
    logic [11:0] lines_total;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_idx = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    game_ctrl_fsm #(
        .GRAV_W(16), .GRAV_BASE(8), .GRAV_STEP(2), .GRAV_MIN(2), .LOCK_TICKS(4),
        .LEVEL_W(4), .LINES_W(12), .LINES_PER_LEVEL(2)
    ) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .restart(restart), .start(start),
        .pause(pause), .placed(placed), .game_over(game_over), .spawn_done(spawn_done),
        .clear_done(clear_done), .lines_cleared(lines_cleared), .state(state),
        .spawn_req(spawn_req), .clear_req(clear_req), .drop_tick(drop_tick),
        .level(level), .lines_total(lines_total)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at step %0d: got %0d, expected %0d", nm, step_idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] in_b, input logic [2:0] lc,
                                input logic [2:0] es, input logic [2:0] eo,
                                input logic [3:0] elv, input logic [11:0] eln);
        vec_t v;
        v.in_b = in_b; v.lc = lc; v.es = es; v.eo = eo; v.elv = elv; v.eln = eln;
        return v;
    endfunction

    function automatic void add(input logic [6:0] in_b, input logic [2:0] lc,
                                input logic [2:0] es, input logic [2:0] eo,
                                input logic [3:0] elv, input logic [11:0] eln);
        tbl.push_back(mk(in_b, lc, es, eo, elv, eln));
    endfunction

    // n idle FALL cycles; ticks on cycle `first` and every `per` after (1-based).
    function automatic void fall_rows(input int n, input int first, input int per,
                                      input logic [3:0] lv, input logic [11:0] ln);
        for (int k = 1; k <= n; k++) begin
            add(7'd0, 3'd0, S_FALL,
                ((k >= first) && (((k - first) % per) == 0)) ? O_TK : 3'd0, lv, ln);
        end
    endfunction

    // From FALL: ground the piece, lock after 4 clocks, clear lc rows, respawn into FALL.
    function automatic void lock_clear(input logic [2:0] lc, input logic [3:0] olv,
                                       input logic [11:0] oln, input logic [3:0] nlv,
                                       input logic [11:0] nln);
        add(I_PL, 3'd0, S_LOCK, 3'd0, olv, oln);
        for (int k = 0; k < 3; k++) add(I_PL, 3'd0, S_LOCK, 3'd0, olv, oln);
        add(I_PL, 3'd0, S_CLEAR, 3'd0, olv, oln);
        add(7'd0, 3'd0, S_CLEAR, O_CR, olv, oln);
        add(I_CD, lc, S_SPAWN, O_CR, nlv, nln);
        add(I_SD, 3'd0, S_FALL, O_SR, nlv, nln);
    endfunction

    task automatic apply(input vec_t v);
        vec_t e;
        {restart, start, pause, placed, game_over, spawn_done, clear_done} = v.in_b;
        lines_cleared = v.lc;
        exp_q.push_back(v);
        @(posedge in_clk);
        #1;
        step_idx++;
        e = exp_q.pop_front();
        chk("state", state, e.es);
        chk("spawn_req", spawn_req, e.eo[2]);
        chk("clear_req", clear_req, e.eo[1]);
        chk("drop_tick", drop_tick, e.eo[0]);
        chk("level", level, e.elv);
        chk("lines_total", lines_total, e.eln);
    endtask

    task automatic ap(input logic [6:0] in_b, input logic [2:0] lc, input logic [2:0] es,
                      input logic [2:0] eo, input logic [3:0] elv, input logic [11:0] eln);
        apply(mk(in_b, lc, es, eo, elv, eln));
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        in_rst_n = 1'b0;
        {restart, start, pause, placed, game_over, spawn_done, clear_done} = 7'd0;
        lines_cleared = 3'd0;

        // Main flow table.
        add(I_ST, 3'd0, S_SPAWN, 3'd0, 4'd0, 12'd0);
        add(I_SD, 3'd0, S_FALL, O_SR, 4'd0, 12'd0);
        fall_rows(16, 8, 8, 4'd0, 12'd0);
        fall_rows(3, 99, 8, 4'd0, 12'd0);
        add(I_PL, 3'd0, S_LOCK, 3'd0, 4'd0, 12'd0);
        add(I_PL, 3'd0, S_LOCK, 3'd0, 4'd0, 12'd0);
        add(I_PL, 3'd0, S_LOCK, 3'd0, 4'd0, 12'd0);
        add(7'd0, 3'd0, S_FALL, 3'd0, 4'd0, 12'd0);
        fall_rows(5, 5, 8, 4'd0, 12'd0);
        lock_clear(3'd1, 4'd0, 12'd0, 4'd0, 12'd1);
        lock_clear(3'd1, 4'd0, 12'd1, 4'd1, 12'd2);
        lock_clear(3'd1, 4'd1, 12'd2, 4'd1, 12'd3);
        fall_rows(12, 6, 6, 4'd1, 12'd3);
        lock_clear(3'd4, 4'd1, 12'd3, 4'd2, 12'd7);
        fall_rows(8, 4, 4, 4'd2, 12'd7);
        fall_rows(3, 99, 4, 4'd2, 12'd7);
        add(I_PL, 3'd0, S_LOCK, 3'd0, 4'd2, 12'd7);
        add(7'd0, 3'd0, S_FALL, 3'd0, 4'd2, 12'd7);
        add(7'd0, 3'd0, S_FALL, O_TK, 4'd2, 12'd7);

        // Reset values.
        @(posedge in_clk);
        @(posedge in_clk);
        #1;
        chk("rst_state", state, S_IDLE);
        chk("rst_spawn_req", spawn_req, 1'b0);
        chk("rst_clear_req", clear_req, 1'b0);
        chk("rst_drop_tick", drop_tick, 1'b0);
        chk("rst_level", level, 4'd0);
        chk("rst_lines", lines_total, 12'd0);
        in_rst_n = 1'b1;

        run_tbl();

        // Restart clears level and lines.
        ap(I_RS, 3'd0, S_IDLE, 3'd0, 4'd0, 12'd0);

        // Pause at counter 5, frozen 20 clocks, tick 3 clocks after resume.
        ap(I_ST, 3'd0, S_SPAWN, 3'd0, 4'd0, 12'd0);
        ap(I_PA, 3'd0, S_SPAWN, O_SR, 4'd0, 12'd0);
        ap(I_SD, 3'd0, S_FALL, O_SR, 4'd0, 12'd0);
        for (int k = 0; k < 5; k++) ap(7'd0, 3'd0, S_FALL, 3'd0, 4'd0, 12'd0);
        ap(I_PA, 3'd0, S_PAUSE, 3'd0, 4'd0, 12'd0);
        for (int k = 0; k < 20; k++) ap(7'd0, 3'd0, S_PAUSE, 3'd0, 4'd0, 12'd0);
        ap(I_PA, 3'd0, S_FALL, 3'd0, 4'd0, 12'd0);
        ap(7'd0, 3'd0, S_FALL, 3'd0, 4'd0, 12'd0);
        ap(7'd0, 3'd0, S_FALL, 3'd0, 4'd0, 12'd0);
        ap(7'd0, 3'd0, S_FALL, O_TK, 4'd0, 12'd0);

        // Pause from LOCK freezes the lock counter; CLEAR ignores pause/game_over.
        ap(I_PL, 3'd0, S_LOCK, 3'd0, 4'd0, 12'd0);
        ap(I_PL | I_PA, 3'd0, S_PAUSE, 3'd0, 4'd0, 12'd0);
        for (int k = 0; k < 3; k++) ap(I_PL, 3'd0, S_PAUSE, 3'd0, 4'd0, 12'd0);
        ap(I_PL | I_PA, 3'd0, S_LOCK, 3'd0, 4'd0, 12'd0);
        for (int k = 0; k < 3; k++) ap(I_PL, 3'd0, S_LOCK, 3'd0, 4'd0, 12'd0);
        ap(I_PL, 3'd0, S_CLEAR, 3'd0, 4'd0, 12'd0);
        ap(I_PA | I_GO, 3'd0, S_CLEAR, O_CR, 4'd0, 12'd0);
        ap(I_CD, 3'd0, S_SPAWN, O_CR, 4'd0, 12'd0);

        // Top-out during spawn needs spawn_done; OVER only left by restart.
        ap(I_GO, 3'd0, S_SPAWN, O_SR, 4'd0, 12'd0);
        ap(I_GO | I_SD, 3'd0, S_OVER, O_SR, 4'd0, 12'd0);
        ap(I_ST, 3'd0, S_OVER, 3'd0, 4'd0, 12'd0);
        ap(I_PA, 3'd0, S_OVER, 3'd0, 4'd0, 12'd0);
        ap(I_RS, 3'd0, S_IDLE, 3'd0, 4'd0, 12'd0);

        // restart beats game_over.
        ap(I_ST, 3'd0, S_SPAWN, 3'd0, 4'd0, 12'd0);
        ap(I_SD, 3'd0, S_FALL, O_SR, 4'd0, 12'd0);
        ap(I_RS | I_GO, 3'd0, S_IDLE, 3'd0, 4'd0, 12'd0);

        // game_over beats pause in LOCK.
        ap(I_ST, 3'd0, S_SPAWN, 3'd0, 4'd0, 12'd0);
        ap(I_SD, 3'd0, S_FALL, O_SR, 4'd0, 12'd0);
        ap(I_PL, 3'd0, S_LOCK, 3'd0, 4'd0, 12'd0);
        ap(I_PL | I_GO | I_PA, 3'd0, S_OVER, 3'd0, 4'd0, 12'd0);
        ap(I_RS, 3'd0, S_IDLE, 3'd0, 4'd0, 12'd0);

        // Build up level/lines, then async reset mid-FALL with no clock edge.
        ap(I_ST, 3'd0, S_SPAWN, 3'd0, 4'd0, 12'd0);
        ap(I_SD, 3'd0, S_FALL, O_SR, 4'd0, 12'd0);
        lock_clear(3'd3, 4'd0, 12'd0, 4'd1, 12'd3);
        fall_rows(2, 99, 6, 4'd1, 12'd3);
        run_tbl();
        #2;
        in_rst_n = 1'b0;
        #1;
        chk("async_state", state, S_IDLE);
        chk("async_level", level, 4'd0);
        chk("async_lines", lines_total, 12'd0);
        chk("async_tick", drop_tick, 1'b0);
        @(posedge in_clk);
        #1;
        in_rst_n = 1'b1;
        ap(7'd0, 3'd0, S_IDLE, 3'd0, 4'd0, 12'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
